// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/halt/single-step controller with retired-instruction counter
// Optional PC breakpoint (BRK state, resume, bp_hit) enabled by `define CPU_RUN_CTRL_BP_EN.
module cpu_run_ctrl #(
   parameter bit RESET_RUN = 1'b0,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             step_req,
   input  logic             cnt_clr,
   input  logic [31:0]      pc_pc,
   input  logic             bp_valid,
   input  logic [31:0]      bp_addr,
   output logic             cpu_en,
   output logic [1:0]       state,
   output logic             halted,
   output logic             bp_hit,
   output logic [CNT_W-1:0] inst_cnt
);

   typedef enum logic [1:0] {
      S_HALT = 2'b00,
      S_RUN  = 2'b01,
      S_STEP = 2'b10,
      S_BRK  = 2'b11
   } state_e;

   localparam state_e RST_STATE = RESET_RUN ? S_RUN : S_HALT;

   state_e           state_q, state_d;
   logic             resume_q, resume_d;
   logic             bp_hit_q, bp_hit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bp_match;
   logic             en;

`ifdef CPU_RUN_CTRL_BP_EN
   // resume masks the compare for the first RUN cycle after BRK so the
   // breakpointed instruction can retire.
   assign bp_match = bp_valid && (pc_pc == bp_addr) && !resume_q;
   assign bp_hit   = bp_hit_q;
`else
   logic unused_bp;
   assign bp_match  = 1'b0;
   assign bp_hit    = 1'b0;
   assign unused_bp = ^{bp_valid, bp_addr, pc_pc, bp_hit_q, resume_q};
`endif

   always_comb begin
      state_d  = state_q;
      resume_d = 1'b0;
      bp_hit_d = bp_hit_q;
      en       = 1'b0;
      case (state_q)
         S_HALT: begin
            if (!halt_req) begin
               if (step_req) begin
                  state_d = S_STEP;
               end else if (run_req) begin
                  state_d = S_RUN;
               end
            end
         end
         S_STEP: begin
            en      = 1'b1;
            state_d = S_HALT;
         end
         S_RUN: begin
            if (bp_match) begin
               bp_hit_d = 1'b1;
               state_d  = halt_req ? S_HALT : S_BRK;
            end else begin
               en = 1'b1;
               if (halt_req) begin
                  state_d = S_HALT;
               end
            end
         end
         S_BRK: begin
            if (halt_req || step_req || run_req) begin
               bp_hit_d = 1'b0;
            end
            if (halt_req) begin
               state_d = S_HALT;
            end else if (step_req) begin
               state_d = S_STEP;
            end else if (run_req) begin
               state_d  = S_RUN;
               resume_d = 1'b1;
            end
         end
         default: begin
            state_d = S_HALT;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= RST_STATE;
         resume_q <= 1'b0;
         bp_hit_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         resume_q <= resume_d;
         bp_hit_q <= bp_hit_d;
         cnt_q    <= cnt_d;
      end
   end

   assign cpu_en   = en;
   assign state    = state_q;
   assign halted   = (state_q == S_HALT) || (state_q == S_BRK);
   assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - scoreboard bench for cpu_run_ctrl (CNT_W=4, RESET_RUN=0)
module tb_cpu_run_ctrl;

   localparam logic [4:0] I_IDLE = 5'b00000;
   localparam logic [4:0] I_RUN  = 5'b01000;
   localparam logic [4:0] I_HALT = 5'b00100;
   localparam logic [4:0] I_STEP = 5'b00010;
   localparam logic [4:0] I_CLR  = 5'b00001;
   localparam logic [4:0] I_RST  = 5'b10000;

   localparam logic [1:0] SH = 2'b00;
   localparam logic [1:0] SR = 2'b01;
   localparam logic [1:0] SS = 2'b10;
   localparam logic [1:0] SB = 2'b11;

   logic        clk = 1'b0;
   logic        rst;
   logic        run_req, halt_req, step_req, cnt_clr;
   logic [31:0] pc_pc;
   logic        bp_valid;
   logic [31:0] bp_addr;
   logic        cpu_en;
   logic [1:0]  state;
   logic        halted;
   logic        bp_hit;
   logic [3:0]  inst_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [36:0] stim_q[$];
   logic [8:0]  exp_q[$];

   cpu_run_ctrl #(.RESET_RUN(1'b0), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .run_req(run_req), .halt_req(halt_req),
      .step_req(step_req), .cnt_clr(cnt_clr), .pc_pc(pc_pc),
      .bp_valid(bp_valid), .bp_addr(bp_addr), .cpu_en(cpu_en),
      .state(state), .halted(halted), .bp_hit(bp_hit), .inst_cnt(inst_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] mk(input logic [1:0] st, input logic en,
                                     input logic bph, input int cnt);
      logic h;
      logic [3:0] c;
      h = (st == SH) || (st == SB);
      c = cnt[3:0];
      return {st, en, h, bph, c};
   endfunction

   // Queue one cycle of stimulus with the outputs expected during that cycle.
   task automatic add(input logic [4:0] s, input logic [31:0] bpa, input logic [1:0] st,
                      input logic en, input logic bph, input int cnt);
      stim_q.push_back({s, bpa});
      exp_q.push_back(mk(st, en, bph, cnt));
   endtask

   task automatic test_reset;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      add(I_IDLE, 0, SH, 0, 0, 0);
      add(I_IDLE, 0, SH, 0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL reset cycle %0d: got %h expected %h", i, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
   endtask

   task automatic test_run_halt;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      add(I_RUN, 0, SH, 0, 0, 0);
      for (int k = 0; k < 10; k++) add((k == 4) ? I_RUN : I_IDLE, 0, SR, 1, 0, k);
      add(I_IDLE, 0, SR, 1, 0, 10);
      add(I_HALT, 0, SR, 1, 0, 11);
      add(I_IDLE, 0, SH, 0, 0, 12);
      add(I_IDLE, 0, SH, 0, 0, 12);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL run_halt cycle %0d: got %h expected %h", i, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
   endtask

   task automatic test_step;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      add(I_CLR, 0, SH, 0, 0, 12);
      for (int k = 0; k < 3; k++) begin
         add(I_STEP, 0, SH, 0, 0, k);
         add(I_IDLE, 0, SS, 1, 0, k);
      end
      add(I_IDLE, 0, SH, 0, 0, 3);
      add(I_STEP, 0, SH, 0, 0, 3);
      add(I_STEP, 0, SS, 1, 0, 3);
      add(I_STEP, 0, SH, 0, 0, 4);
      add(I_IDLE, 0, SS, 1, 0, 4);
      add(I_IDLE, 0, SH, 0, 0, 5);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL step cycle %0d: got %h expected %h", i, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
   endtask

   task automatic test_priority;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      add(I_HALT | I_STEP | I_RUN, 0, SH, 0, 0, 5);
      add(I_IDLE, 0, SH, 0, 0, 5);
      add(I_STEP | I_RUN, 0, SH, 0, 0, 5);
      add(I_STEP | I_RUN, 0, SS, 1, 0, 5);
      add(I_IDLE, 0, SH, 0, 0, 6);
      add(I_STEP, 0, SH, 0, 0, 6);
      add(I_HALT, 0, SS, 1, 0, 6);
      add(I_IDLE, 0, SH, 0, 0, 7);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL priority cycle %0d: got %h expected %h", i, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
   endtask

   task automatic test_wrap;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      add(I_CLR, 0, SH, 0, 0, 7);
      add(I_RUN, 0, SH, 0, 0, 0);
      for (int k = 0; k < 15; k++) add(I_IDLE, 0, SR, 1, 0, k);
      add(I_IDLE, 0, SR, 1, 0, 15);
      add(I_IDLE, 0, SR, 1, 0, 0);
      add(I_CLR, 0, SR, 1, 0, 1);
      add(I_HALT, 0, SR, 1, 0, 0);
      add(I_IDLE, 0, SH, 0, 0, 1);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL wrap cycle %0d: got %h expected %h", i, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
   endtask

   // PC advances by 4 on every expected enabled cycle; then reset is applied from RUN.
   task automatic test_breakpoint_reset;
      logic [36:0] s;
      logic [8:0]  e, obs;
      int i = 0;
      pc_pc    = 32'h0;
      bp_valid = 1'b1;
      add(I_CLR, 32'h10, SH, 0, 0, 1);
      add(I_RUN, 32'h10, SH, 0, 0, 0);
      for (int k = 0; k < 4; k++) add(I_IDLE, 32'h10, SR, 1, 0, k);
`ifdef CPU_RUN_CTRL_BP_EN
      add(I_IDLE, 32'h10, SR, 0, 0, 4);
      add(I_IDLE, 32'h10, SB, 0, 1, 4);
      add(I_RUN,  32'h10, SB, 0, 1, 4);
      add(I_IDLE, 32'h10, SR, 1, 0, 4);
      add(I_IDLE, 32'h10, SR, 1, 0, 5);
      add(I_HALT, 32'h18, SR, 0, 0, 6);
      add(I_IDLE, 32'h18, SH, 0, 1, 6);
      add(I_RUN,  32'h40, SH, 0, 1, 6);
      add(I_IDLE, 32'h40, SR, 1, 1, 6);
      add(I_RST,  32'h40, SR, 1, 1, 7);
`else
      add(I_IDLE, 32'h10, SR, 1, 0, 4);
      add(I_IDLE, 32'h10, SR, 1, 0, 5);
      add(I_HALT, 32'h18, SR, 1, 0, 6);
      add(I_IDLE, 32'h18, SH, 0, 0, 7);
      add(I_RUN,  32'h40, SH, 0, 0, 7);
      add(I_IDLE, 32'h40, SR, 1, 0, 7);
      add(I_RST,  32'h40, SR, 1, 0, 8);
`endif
      add(I_RST | I_RUN, 32'h40, SH, 0, 0, 0);
      add(I_IDLE, 32'h40, SH, 0, 0, 0);
      add(I_IDLE, 32'h40, SH, 0, 0, 0);
      while (stim_q.size() > 0) begin
         s = stim_q.pop_front(); e = exp_q.pop_front();
         @(negedge clk);
         {rst, run_req, halt_req, step_req, cnt_clr} = s[36:32]; bp_addr = s[31:0];
         #1;
         obs = {state, cpu_en, halted, bp_hit, inst_cnt};
         n_checks++;
         if (obs !== e) begin
            n_fail++;
            $display("FAIL bp_reset cycle %0d pc %h: got %h expected %h", i, pc_pc, obs, e);
         end
         if (e[6]) pc_pc = pc_pc + 32'd4;
         i++;
      end
      bp_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; cnt_clr = 1'b0;
      pc_pc = 32'h0; bp_valid = 1'b0; bp_addr = 32'h0;
      repeat (2) @(posedge clk);
      test_reset;
      test_run_halt;
      test_step;
      test_priority;
      test_wrap;
      test_breakpoint_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/halt/single-step controller for the single-cycle miniCPU. Produces one clock-enable, `cpu_en`, that gates every architectural state update (PC, RF write, DRAM write), so each cycle with `cpu_en`=1 retires exactly one instruction. Driven by a debug/board interface with run, halt and step requests and an optional PC breakpoint. Also keeps a retired-instruction counter.

## Interface

Parameters:
- `RESET_RUN`, default 0: 1 = leave reset in RUN; 0 = leave reset in HALT.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: the only clock. All state changes on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `run_req` in 1: single-cycle pulse requesting free-running execution.
- `halt_req` in 1: single-cycle pulse requesting a stop.
- `step_req` in 1: single-cycle pulse requesting execution of one instruction.
- `cnt_clr` in 1: synchronous clear of `inst_cnt`.
- `pc_pc` in 32: current PC from the CPU.
- `bp_valid` in 1: breakpoint armed.
- `bp_addr` in 32: breakpoint PC.
- `cpu_en` out 1: combinational enable to the CPU state elements.
- `state` out 2: HALT=2'b00, RUN=2'b01, STEP=2'b10, BRK=2'b11.
- `halted` out 1: 1 in HALT or BRK.
- `bp_hit` out 1: sticky breakpoint flag.
- `inst_cnt` out CNT_W: count of cycles with `cpu_en`=1.

## Operation

- Request priority when several requests arrive in one cycle: `halt_req` > `step_req` > `run_req`.
- `bp_match` = `bp_valid` && (`pc_pc` == `bp_addr`) && !`resume`. It is forced to 0 when the breakpoint feature is compiled out.
- `cpu_en` = (state==RUN && !`bp_match`) || state==STEP.

State behaviour:
- **HALT**
  - `cpu_en`=0.
  - `step_req` -> STEP.
  - `run_req` -> RUN.
- **STEP**
  - `cpu_en`=1 for exactly one cycle.
  - Next state is always HALT, except `halt_req` also gives HALT.
  - `run_req` and `step_req` received in STEP are dropped.
- **RUN**
  - `halt_req` -> HALT. The instruction in that same cycle still retires.
  - `bp_match` -> BRK with `cpu_en`=0 that cycle, so the breakpointed instruction is NOT executed. `bp_hit` is set.
  - `run_req` is ignored.
  - `halt_req` and `bp_match` in the same cycle -> HALT with `cpu_en`=0, and `bp_hit` is set.
- **BRK**
  - `cpu_en`=0.
  - `run_req` -> RUN and sets `resume`.
  - `step_req` -> STEP.
  - `halt_req` -> HALT.
  - All three exits clear `bp_hit`.

`resume` register:
- Suppresses `bp_match` for exactly the first RUN cycle after leaving BRK, so the instruction at `bp_addr` executes.
- Cleared after that cycle.
- Never set on any other path.

Counter:
- `inst_cnt` increments by 1 on each cycle with `cpu_en`=1.
- Wraps modulo 2^CNT_W.
- `cnt_clr` wins over increment; the counter is 0 on the next cycle.

## Timing

- All requests are sampled on the rising edge. The new `state` is visible the cycle after the request; `cpu_en` follows combinationally.
- Latency:
  - `run_req` to first enabled cycle: 1.
  - `step_req` to its single `cpu_en` cycle: 1.
  - `halt_req` to `cpu_en`=0: 1.
- `bp_match` acts in the same cycle: `cpu_en` drops combinationally while `pc_pc` equals `bp_addr`.
- Reset values:
  - `state` = RUN if `RESET_RUN`, else HALT.
  - `cpu_en` follows `state`.
  - `halted` = !`RESET_RUN`.
  - `bp_hit`=0, `inst_cnt`=0, `resume`=0.
- Reset mid-operation (any state) returns to the reset values on the next edge and discards any pending request.
- Requests held high for several cycles act as repeated pulses. Example: `step_req` held high alternates STEP/HALT.

## Configuration

- Macro: `CPU_RUN_CTRL_BP_EN`.
- Defined:
  - Breakpoint compare, BRK state, `resume` register and `bp_hit` are implemented as described above.
- Undefined:
  - `bp_valid` and `bp_addr` stay as ports but are ignored.
  - `bp_match`=0, BRK is unreachable, and `bp_hit` is tied to 0.

## Test plan

- Reset, `RESET_RUN`=0: `state`=00, `cpu_en`=0, `inst_cnt`=0. `run_req` pulse -> next cycle `state`=01, `cpu_en`=1. After 10 cycles, `inst_cnt`=10.
- In HALT, three `step_req` pulses 2 cycles apart -> three isolated single `cpu_en` cycles. `inst_cnt`=3; `state` returns to 00 after each step.
- RUN with `bp_valid`=1, `bp_addr`=0x0000_0010, PC counting 0,4,8,…:
  - At `pc_pc`=0x10, `cpu_en`=0 that cycle.
  - `state`=11 and `bp_hit`=1 next cycle; `inst_cnt`=4.
  - `run_req` -> the instruction at 0x10 executes (`inst_cnt`=5), `bp_hit`=0, and there is no re-trigger.
- Same-cycle `halt_req`+`step_req`+`run_req` in HALT -> stays 00. Same-cycle `step_req`+`run_req` -> 10 for one cycle, then 00.
- `inst_cnt` preset near wrap (CNT_W=4, 15 retirements) -> next retirement gives 0. `cnt_clr` together with `cpu_en` -> 0.
- `rst` asserted while in RUN with `bp_hit`=1 -> next cycle all outputs at reset values. With the macro undefined, a matching `bp_addr` never stops RUN.
